// File: rtl/sprite_scheduler_if.sv
// Position-update handshake between the sprite position source and the scheduler.
interface sprite_scheduler_if;
  logic       upd_valid;
  logic [1:0] upd_id;
  logic [9:0] upd_h;
  logic [9:0] upd_v;
  logic       upd_en;
  logic       upd_ready;

  modport master (output upd_valid, upd_id, upd_h, upd_v, upd_en, input upd_ready);
  modport slave  (input upd_valid, upd_id, upd_h, upd_v, upd_en, output upd_ready);
endinterface

// File: rtl/sprite_scheduler.sv
// Sprite scheduler: double-buffered sprite positions committed once per vblank,
// plus a 2-stage hit/priority pipeline that drives a shared sprite ROM address.
//
// state  | meaning
// RUN    | active video; updates land in shadow, waiting for vblank entry
// COMMIT | copying shadow[cnt] -> active[cnt], one slot per cycle
// VBWAIT | commit done; waiting for v_cnt to leave vblank
module sprite_scheduler #(
  parameter int NSPR = 4,
  parameter int SW   = 20,
  parameter int SSZ  = 400
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  sprite_scheduler_if.slave  upd,
  output logic [16:0]        rom_addr,
  output logic               pix_hit,
  output logic [1:0]         pix_id
);

  typedef enum logic [1:0] {RUN, COMMIT, VBWAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        in_vb_q, in_vb_d;
  logic        vb_now;
  logic        upd_ready_w;
  logic        commit_en;

  logic [9:0]  sh_h_q  [NSPR];
  logic [9:0]  sh_h_d  [NSPR];
  logic [9:0]  sh_v_q  [NSPR];
  logic [9:0]  sh_v_d  [NSPR];
  logic        sh_en_q [NSPR];
  logic        sh_en_d [NSPR];
  logic [9:0]  act_h_q [NSPR];
  logic [9:0]  act_h_d [NSPR];
  logic [9:0]  act_v_q [NSPR];
  logic [9:0]  act_v_d [NSPR];
  logic        act_en_q[NSPR];
  logic        act_en_d[NSPR];

  logic [16:0] rom_addr_q, rom_addr_d;
  logic        hit_q, hit_d;
  logic [1:0]  id_q, id_d;
  logic        pix_hit_q;
  logic [1:0]  pix_id_q;

  logic [10:0] h11, v11;

  assign vb_now  = (v_cnt >= 10'd480);
  assign in_vb_d = vb_now;
  assign h11     = {1'b0, h_cnt};
  assign v11     = {1'b0, v_cnt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      in_vb_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_vb_q <= in_vb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (vb_now && !in_vb_q) begin
          state_d = COMMIT;
          cnt_d   = '0;
        end
      end
      COMMIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(NSPR - 1)) state_d = VBWAIT;
      end
      VBWAIT: begin
        if (!vb_now) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    upd_ready_w = (state_q != COMMIT);
    commit_en   = (state_q == COMMIT);
  end

  assign upd.upd_ready = upd_ready_w;

  // No update can be accepted while committing, so shadow is stable during the copy.
  always_comb begin
    sh_h_d   = sh_h_q;
    sh_v_d   = sh_v_q;
    sh_en_d  = sh_en_q;
    act_h_d  = act_h_q;
    act_v_d  = act_v_q;
    act_en_d = act_en_q;
    if (upd.upd_valid && upd_ready_w) begin
      sh_h_d[upd.upd_id]  = upd.upd_h;
      sh_v_d[upd.upd_id]  = upd.upd_v;
      sh_en_d[upd.upd_id] = upd.upd_en;
    end
    if (commit_en) begin
      act_h_d[cnt_q]  = sh_h_q[cnt_q];
      act_v_d[cnt_q]  = sh_v_q[cnt_q];
      act_en_d[cnt_q] = sh_en_q[cnt_q];
    end
  end

  // Descending scan so the lowest-index hit is the last one written and wins.
  always_comb begin
    hit_d      = 1'b0;
    id_d       = '0;
    rom_addr_d = '0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (act_en_q[i] &&
          h11 >= {1'b0, act_h_q[i]} && h11 < {1'b0, act_h_q[i]} + 11'(SW) &&
          v11 >= {1'b0, act_v_q[i]} && v11 < {1'b0, act_v_q[i]} + 11'(SW)) begin
        hit_d      = 1'b1;
        id_d       = 2'(i);
        rom_addr_d = 17'(i * SSZ)
                   + 17'(v11 - {1'b0, act_v_q[i]}) * 17'(SW)
                   + 17'(h11 - {1'b0, act_h_q[i]});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSPR; i++) begin
        sh_h_q[i]   <= '0;
        sh_v_q[i]   <= '0;
        sh_en_q[i]  <= 1'b0;
        act_h_q[i]  <= '0;
        act_v_q[i]  <= '0;
        act_en_q[i] <= 1'b0;
      end
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      id_q       <= '0;
      pix_hit_q  <= 1'b0;
      pix_id_q   <= '0;
    end else begin
      sh_h_q     <= sh_h_d;
      sh_v_q     <= sh_v_d;
      sh_en_q    <= sh_en_d;
      act_h_q    <= act_h_d;
      act_v_q    <= act_v_d;
      act_en_q   <= act_en_d;
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_d;
      id_q       <= id_d;
      pix_hit_q  <= hit_q;
      pix_id_q   <= id_q;
    end
  end

  assign rom_addr = rom_addr_q;
  assign pix_hit  = pix_hit_q;
  assign pix_id   = pix_id_q;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sprite_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [16:0] rom_addr;
  logic        pix_hit;
  logic [1:0]  pix_id;

  sprite_scheduler_if bus();

  sprite_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .upd      (bus),
    .rom_addr (rom_addr),
    .pix_hit  (pix_hit),
    .pix_id   (pix_id)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: shadow table written by accepted updates; active table
  // is a snapshot of shadow taken at each vblank entry, with the 4-cycle
  // commit window modelled as a busy count that blocks updates.
  int m_sh_h[4], m_sh_v[4], m_act_h[4], m_act_v[4];
  bit m_sh_en[4], m_act_en[4];
  bit m_prev_vb, m_wait, m_ready;
  int m_busy;
  bit e1_hit, e1_chk, e2_hit, e2_chk;
  int e1_id, e1_addr, e2_id;
  bit t_hit, t_vb, t_acc;
  int t_id, t_addr;

  function automatic void model_pixel(input int h, input int v,
                                      output bit hit, output int id, output int addr);
    hit = 0; id = 0; addr = 0;
    for (int i = 0; i < 4; i++)
      if (!hit && m_act_en[i] && h >= m_act_h[i] && h < m_act_h[i] + 20 &&
          v >= m_act_v[i] && v < m_act_v[i] + 20) begin
        hit  = 1;
        id   = i;
        addr = i * 400 + (v - m_act_v[i]) * 20 + (h - m_act_h[i]);
      end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_sh_h[i] = 0; m_sh_v[i] = 0; m_sh_en[i] = 0;
        m_act_h[i] = 0; m_act_v[i] = 0; m_act_en[i] = 0;
      end
      m_prev_vb = 1; m_wait = 0; m_busy = 0; m_ready = 1;
      e1_hit = 0; e1_id = 0; e1_addr = 0; e1_chk = 1;
      e2_hit = 0; e2_id = 0; e2_chk = 1;
    end else begin
      t_vb  = (v_cnt >= 480);
      t_acc = bus.upd_valid && m_ready;
      e2_hit = e1_hit; e2_id = e1_id; e2_chk = e1_chk;
      model_pixel(int'(h_cnt), int'(v_cnt), t_hit, t_id, t_addr);
      e1_hit = t_hit; e1_id = t_id; e1_addr = t_addr;
      e1_chk = !t_vb && (m_busy == 0);
      if (t_acc) begin
        m_sh_h[bus.upd_id]  = int'(bus.upd_h);
        m_sh_v[bus.upd_id]  = int'(bus.upd_v);
        m_sh_en[bus.upd_id] = bus.upd_en;
      end
      if (m_busy > 0) m_busy--;
      else if (m_wait) begin
        if (!t_vb) m_wait = 0;
      end else if (t_vb && !m_prev_vb) begin
        for (int i = 0; i < 4; i++) begin
          m_act_h[i] = m_sh_h[i]; m_act_v[i] = m_sh_v[i]; m_act_en[i] = m_sh_en[i];
        end
        m_busy = 4;
        m_wait = 1;
      end
      m_prev_vb = t_vb;
      m_ready   = (m_busy == 0);
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      check("model_upd_ready", bus.upd_ready, m_ready);
      if (e1_chk) check("model_rom_addr", rom_addr, e1_addr);
      if (e2_chk) begin
        check("model_pix_hit", pix_hit, e2_hit);
        check("model_pix_id", pix_id, e2_id);
      end
    end
  end

  task automatic upd(input int id, input int h, input int v, input bit en);
    bit acc;
    acc = 0;
    @(negedge clk);
    bus.upd_valid = 1; bus.upd_id = 2'(id); bus.upd_h = 10'(h);
    bus.upd_v = 10'(v); bus.upd_en = en;
    for (int k = 0; k < 20 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      acc = bus.upd_ready;
      @(posedge clk);
    end
    if (!acc) begin
      n_chk++;
      $display("FAIL upd_timeout: slot %0d never accepted, required acceptance", id);
    end
    @(negedge clk);
    bus.upd_valid = 0;
  endtask

  task automatic probe(input string tag, input int h, input int v,
                       input int ea, input int eh, input int ei);
    @(negedge clk);
    h_cnt = 10'(h); v_cnt = 10'(v);
    @(posedge clk); #2;
    check({tag, "_addr"}, rom_addr, ea);
    @(posedge clk); #2;
    check({tag, "_hit"}, pix_hit, eh);
    check({tag, "_id"}, pix_id, ei);
  endtask

  task automatic vblank();
    @(negedge clk);
    h_cnt = 0; v_cnt = 480;
    repeat (8) @(negedge clk);
    v_cnt = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bus.upd_valid = 0; bus.upd_id = 0; bus.upd_h = 0; bus.upd_v = 0; bus.upd_en = 0;
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", bus.upd_ready, 1);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_pix_hit", pix_hit, 0);
    check("rst_pix_id", pix_id, 0);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);

    // single sprite, visible only after the next commit
    upd(0, 100, 50, 1);
    probe("pre_vb", 105, 52, 0, 0, 0);
    vblank();
    probe("post_vb", 105, 52, 45, 1, 0);

    // overlap priority
    upd(1, 0, 0, 1);
    upd(3, 10, 10, 1);
    vblank();
    probe("prio_12", 12, 12, 652, 1, 1);
    probe("prio_25", 25, 25, 1515, 1, 3);

    // right-edge clipping, no wrap to column 0
    upd(2, 1015, 100, 1);
    vblank();
    probe("edge_1020", 1020, 105, 905, 1, 2);
    probe("edge_3", 3, 105, 0, 0, 0);

    // ready low for the commit; update held through commit lands next frame
    @(negedge clk); h_cnt = 0; v_cnt = 480;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #2;
      check("ready_commit", bus.upd_ready, (k < 4) ? 0 : 1);
      if (k == 0) begin
        @(negedge clk);
        bus.upd_valid = 1; bus.upd_id = 0; bus.upd_h = 200; bus.upd_v = 200; bus.upd_en = 1;
      end
      if (k == 5) begin
        @(negedge clk); bus.upd_valid = 0;
      end
    end
    @(negedge clk); v_cnt = 0;
    repeat (2) @(negedge clk);
    probe("held_old", 105, 52, 45, 1, 0);
    probe("held_new_pre", 205, 205, 0, 0, 0);
    vblank();
    probe("held_new_post", 205, 205, 105, 1, 0);

    // update accepted on the vblank-entry edge is part of that commit
    @(negedge clk);
    h_cnt = 0; v_cnt = 480;
    bus.upd_valid = 1; bus.upd_id = 1; bus.upd_h = 300; bus.upd_v = 300; bus.upd_en = 1;
    @(negedge clk); bus.upd_valid = 0;
    repeat (7) @(negedge clk);
    v_cnt = 0;
    repeat (2) @(negedge clk);
    probe("entry_upd", 301, 301, 421, 1, 1);

    // reset inside vblank: no commit until a fresh vblank entry
    @(negedge clk); v_cnt = 490; rst = 1;
    @(posedge clk); #2;
    check("rst_vb_ready", bus.upd_ready, 1);
    check("rst_vb_pix_hit", pix_hit, 0);
    @(negedge clk); rst = 0;
    upd(0, 100, 50, 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #2;
      check("ready_no_commit", bus.upd_ready, 1);
    end
    @(negedge clk); v_cnt = 0;
    repeat (3) @(negedge clk);
    probe("no_commit_after_rst", 105, 52, 0, 0, 0);

    // reset at commit cycle 2 leaves every active slot cleared
    @(negedge clk); h_cnt = 0; v_cnt = 480;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #2;
    check("rst_mid_ready", bus.upd_ready, 1);
    check("rst_mid_pix_hit", pix_hit, 0);
    @(negedge clk); rst = 0; v_cnt = 0;
    repeat (3) @(negedge clk);
    probe("rst_mid_cleared", 105, 52, 0, 0, 0);
    vblank();
    probe("rst_mid_shadow", 105, 52, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sprite_scheduler.md
SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL have parameters: NSPR 4, number of sprite slots; SW 20, sprite width/height in pixels; SSZ 400, ROM words per sprite (SW*SW).
REQ-002 SHALL have port: clk  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: h_cnt  in  10  current pixel column from VGA timing.
REQ-005 SHALL have port: v_cnt  in  10  current pixel row from VGA timing.
REQ-006 SHALL have port: upd_valid  in  1  position update request.
REQ-007 SHALL have port: upd_id  in  2  target sprite slot.
REQ-008 SHALL have port: upd_h, upd_v  in  10 each  new top-left position.
REQ-009 SHALL have port: upd_en  in  1  new slot enable.
REQ-010 SHALL have port: upd_ready  out  1  update accepted when upd_valid && upd_ready.
REQ-011 SHALL have port: rom_addr  out  17  shared sprite ROM address.
REQ-012 SHALL have port: pix_hit  out  1  current pixel covered by a sprite, aligned to ROM data.
REQ-013 SHALL have port: pix_id  out  2  winning slot, aligned with pix_hit.

Function
REQ-014 SHALL hold per slot a shadow set {h,v,en}, written by accepted updates, and an active set {h,v,en}, used for hit testing.
REQ-015 SHALL write an accepted update into shadow[upd_id] at that clock edge; a later update to the same slot overwrites it.
REQ-016 SHALL run FSM states RUN, COMMIT, VBWAIT.
REQ-017 SHALL drive upd_ready=1 in RUN and VBWAIT, and 0 in COMMIT.
REQ-018 SHALL keep a registered in_vb = (v_cnt>=480).
REQ-019 SHALL leave RUN for COMMIT on the edge where v_cnt>=480 and in_vb==0 (vblank entry).
REQ-020 SHALL, in COMMIT, copy shadow[k] to active[k] for k=0..NSPR-1, one slot per cycle, using a 2-bit counter; this takes exactly NSPR cycles, then goes to VBWAIT.
REQ-021 SHALL leave VBWAIT for RUN when v_cnt<480; so exactly one commit per frame.
REQ-022 SHALL include in the commit an update accepted on the vblank-entry cycle itself.
REQ-023 SHALL compute stage 1 (combinational, registered at clk) per slot i: hit_i = en_i && h_cnt>=h_i && h_cnt<h_i+SW && v_cnt>=v_i && v_cnt<v_i+SW.
REQ-024 SHALL do the hit_i comparisons at 11-bit width, so a sprite near the 1023 edge clips and never wraps.
REQ-025 SHALL resolve overlapping hits by fixed priority: lowest index wins.
REQ-026 SHALL compute rom_addr = i*SSZ + (v_cnt-v_i)*SW + (h_cnt-h_i) for winner i, and 0 when there is no hit; the result is 17-bit with no modulo.
REQ-027 SHALL register rom_addr, plus internal hit/id, one cycle after h_cnt/v_cnt.
REQ-028 SHALL delay hit/id one more cycle onto pix_hit/pix_id, giving a latency of 2 cycles from h_cnt/v_cnt, which matches a 1-cycle ROM.
REQ-029 SHALL not stall the hit pipeline during COMMIT, which uses active values mid-copy; this is harmless because it occurs only in vblank.

Reset
REQ-030 SHALL clear all shadow and active h, v, en to 0 on rst.
REQ-031 SHALL set state=RUN, counter=0 and in_vb=1 on rst, so reset during vblank causes no commit until the next vblank entry.
REQ-032 SHALL set upd_ready=1, rom_addr=0, pix_hit=0 and pix_id=0 on rst.
REQ-033 SHALL abort an in-progress COMMIT when rst is asserted mid-COMMIT, leaving all active slots cleared.

Verification
REQ-034 SHALL pass: update id0 (h=100,v=50,en=1) in RUN; h=105,v=52 before vblank -> pix_hit=0; after next vblank entry plus 4 cycles, h=105,v=52 -> 1 cycle later rom_addr=45, 2 cycles later pix_hit=1, pix_id=0.
REQ-035 SHALL pass: slots 1 (h=0,v=0) and 3 (h=10,v=10) enabled; pixel (12,12) -> pix_id=1, rom_addr=400+252=652; pixel (25,25) -> pix_id=3, rom_addr=1200+15*20+15=1515.
REQ-036 SHALL pass: slot 2 at h=1015; pixel h_cnt=1020 -> hit with column offset 5; h_cnt=3 -> no hit (no wrap).
REQ-037 SHALL pass: vblank entry -> upd_ready low exactly 4 cycles; upd_valid held through COMMIT is accepted on the first VBWAIT cycle and committed at the following frame, not this one.
REQ-038 SHALL pass: rst asserted with v_cnt=490 and released there -> no COMMIT until v_cnt goes <480 and back to 480; assert rst at COMMIT cycle 2 -> all active slots cleared, pix_hit=0.
